// File: rtl/matmul_accel.sv
// matmul_accel: memory-mapped DIMxDIM matrix multiply (C = A x B) on the xif bus.
// One sequential MAC; status register, cycle counter, abortable clear sweep.
// Optional: define MATMUL_ACCEL_IRQ_EN to enable the completion interrupt on irq_o.
module matmul_accel #(
    parameter logic [31:0] BASE_ADDR = 32'hC000_0000,
    parameter int unsigned DIM       = 8,
    parameter int unsigned DATA_W    = 32
) (
    input  logic        clk_i,
    input  logic        rst_n_i,
    input  logic        bus_req_i,
    input  logic        bus_we_i,
    input  logic [31:0] bus_addr_bi,
    input  logic [3:0]  bus_be_bi,
    input  logic [31:0] bus_wdata_bi,
    output logic        bus_ack_o,
    output logic        bus_resp_o,
    output logic [31:0] bus_rdata_bo,
    output logic        irq_o
);

    localparam int unsigned N_ELEM = DIM * DIM;
    localparam int unsigned IDX_W  = $clog2(DIM);
    localparam int unsigned K_W    = $clog2(N_ELEM);

    localparam logic [1:0] RGN_REG = 2'b00;
    localparam logic [1:0] RGN_A   = 2'b01;
    localparam logic [1:0] RGN_B   = 2'b10;
    localparam logic [1:0] RGN_C   = 2'b11;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_MAC   = 2'd1,
        ST_STORE = 2'd2,
        ST_CLR   = 2'd3
    } state_t;

    state_t state_q, state_d;

    // Operand and result stores (contents undefined after reset)
    logic [DATA_W-1:0] a_mem [N_ELEM];
    logic [DATA_W-1:0] b_mem [N_ELEM];
    logic [DATA_W-1:0] c_mem [N_ELEM];

    logic [IDX_W-1:0]  i_q, j_q, p_q;
    logic [K_W-1:0]    clr_q;
    logic [DATA_W-1:0] acc_q;
    logic [31:0]       cycles_q;
    logic              done_q;
    logic              resp_q;
    logic [31:0]       rdata_q;
    logic              irq_en_c;

    // Address decode
    logic             hit;
    logic             rd_acc, wr_acc;
    logic [1:0]       region;
    logic [7:0]       word;
    logic             elem_ok;
    logic [K_W-1:0]   elem_idx;
    logic             ctrl_wr;
    logic             start_req, clear_req, start_go;
    logic             ab_wr_ok;

    assign hit       = (bus_addr_bi[31:12] == BASE_ADDR[31:12]);
    assign bus_ack_o = bus_req_i & hit;
    assign rd_acc    = bus_ack_o & ~bus_we_i;
    assign wr_acc    = bus_ack_o & bus_we_i;
    assign region    = bus_addr_bi[11:10];
    assign word      = bus_addr_bi[9:2];
    assign elem_ok   = (32'(word) < N_ELEM);
    assign elem_idx  = K_W'(word);
    assign ctrl_wr   = wr_acc & (region == RGN_REG) & (word == 8'd0) & bus_be_bi[0];
    assign start_req = ctrl_wr & bus_wdata_bi[0];
    assign clear_req = ctrl_wr & bus_wdata_bi[1];
    assign start_go  = start_req & ~clear_req & (state_q == ST_IDLE);
    assign ab_wr_ok  = wr_acc & elem_ok & (state_q == ST_IDLE);

    logic unused_addr_lsb;
    assign unused_addr_lsb = ^bus_addr_bi[1:0];

    // Datapath indices and product
    logic              last_p, last_col, last_elem, last_clr;
    logic [K_W-1:0]    a_idx, b_idx, c_idx;
    logic [DATA_W-1:0] prod_c;

    assign last_p    = (p_q == IDX_W'(DIM - 1));
    assign last_col  = (j_q == IDX_W'(DIM - 1));
    assign last_elem = last_col & (i_q == IDX_W'(DIM - 1));
    assign last_clr  = (clr_q == K_W'(N_ELEM - 1));
    assign a_idx     = K_W'(i_q) * K_W'(DIM) + K_W'(p_q);
    assign b_idx     = K_W'(p_q) * K_W'(DIM) + K_W'(j_q);
    assign c_idx     = K_W'(i_q) * K_W'(DIM) + K_W'(j_q);
    assign prod_c    = a_mem[a_idx] * b_mem[b_idx];

    // Merge enabled bytes of a bus write into an existing element
    function automatic logic [DATA_W-1:0] be_merge(
        input logic [DATA_W-1:0] old_v,
        input logic [31:0]       new_v,
        input logic [3:0]        be
    );
        logic [31:0] m;
        m = 32'(old_v);
        for (int b = 0; b < 4; b++) begin
            if (be[b]) m[8*b +: 8] = new_v[8*b +: 8];
        end
        return DATA_W'(m);
    endfunction

    // FSM state register
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) state_q <= ST_IDLE;
        else          state_q <= state_d;
    end

    // FSM next state and status outputs; CLEAR overrides everything
    logic busy_c, clearing_c;
    always_comb begin
        state_d    = state_q;
        busy_c     = 1'b0;
        clearing_c = 1'b0;
        unique case (state_q)
            ST_IDLE:  if (start_req) state_d = ST_MAC;
            ST_MAC: begin
                busy_c = 1'b1;
                if (last_p) state_d = ST_STORE;
            end
            ST_STORE: begin
                busy_c  = 1'b1;
                state_d = last_elem ? ST_IDLE : ST_MAC;
            end
            ST_CLR: begin
                clearing_c = 1'b1;
                if (last_clr) state_d = ST_IDLE;
            end
            default:  state_d = ST_IDLE;
        endcase
        if (clear_req) state_d = ST_CLR;
    end

    // Loop counters, accumulator, cycle counter and DONE flag
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            i_q      <= '0;
            j_q      <= '0;
            p_q      <= '0;
            clr_q    <= '0;
            acc_q    <= '0;
            cycles_q <= '0;
            done_q   <= 1'b0;
        end else begin
            unique case (state_q)
                ST_IDLE: begin
                    if (start_go) begin
                        i_q      <= '0;
                        j_q      <= '0;
                        p_q      <= '0;
                        acc_q    <= '0;
                        cycles_q <= '0;
                        done_q   <= 1'b0;
                    end
                end
                ST_MAC: begin
                    acc_q    <= acc_q + prod_c;
                    p_q      <= last_p ? '0 : p_q + 1'b1;
                    cycles_q <= cycles_q + 32'd1;
                end
                ST_STORE: begin
                    acc_q    <= '0;
                    cycles_q <= cycles_q + 32'd1;
                    if (last_col) begin
                        j_q <= '0;
                        i_q <= i_q + 1'b1;
                    end else begin
                        j_q <= j_q + 1'b1;
                    end
                    if (last_elem) done_q <= 1'b1;
                end
                ST_CLR:   clr_q <= clr_q + 1'b1;
                default:  ;
            endcase
            if (clear_req) begin
                done_q <= 1'b0;
                clr_q  <= '0;
            end
        end
    end

    // Operand stores: byte-enabled writes, only while idle
    always_ff @(posedge clk_i) begin
        if (ab_wr_ok && region == RGN_A) a_mem[elem_idx] <= be_merge(a_mem[elem_idx], bus_wdata_bi, bus_be_bi);
        if (ab_wr_ok && region == RGN_B) b_mem[elem_idx] <= be_merge(b_mem[elem_idx], bus_wdata_bi, bus_be_bi);
    end

    // Result store: written by STORE, zeroed by the clear sweep
    always_ff @(posedge clk_i) begin
        if (state_q == ST_STORE && !clear_req) c_mem[c_idx] <= acc_q;
        else if (state_q == ST_CLR)            c_mem[clr_q] <= '0;
    end

    // Read mux (pre-register)
    logic [31:0] rd_val;
    always_comb begin
        rd_val = '0;
        unique case (region)
            RGN_REG: begin
                unique case (word)
                    8'd0:    rd_val = {29'd0, irq_en_c, 2'b00};
                    8'd1:    rd_val = {29'd0, clearing_c, done_q, busy_c};
                    8'd2:    rd_val = cycles_q;
                    default: rd_val = '0;
                endcase
            end
            RGN_A:   if (elem_ok) rd_val = 32'(a_mem[elem_idx]);
            RGN_B:   if (elem_ok) rd_val = 32'(b_mem[elem_idx]);
            RGN_C:   if (elem_ok) rd_val = 32'(c_mem[elem_idx]);
            default: rd_val = '0;
        endcase
    end

    // Read response: one cycle after ack, data zero otherwise
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            resp_q  <= 1'b0;
            rdata_q <= '0;
        end else begin
            resp_q  <= rd_acc;
            rdata_q <= rd_acc ? rd_val : 32'd0;
        end
    end

    assign bus_resp_o   = resp_q;
    assign bus_rdata_bo = rdata_q;

`ifdef MATMUL_ACCEL_IRQ_EN
    logic irq_en_q, irq_q;

    // Interrupt enable and registered completion interrupt
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            irq_en_q <= 1'b0;
            irq_q    <= 1'b0;
        end else begin
            if (ctrl_wr) irq_en_q <= bus_wdata_bi[2];
            irq_q <= (start_go | clear_req) ? 1'b0 : (done_q & irq_en_q);
        end
    end

    assign irq_en_c = irq_en_q;
    assign irq_o    = irq_q;
`else
    assign irq_en_c = 1'b0;
    assign irq_o    = 1'b0;
`endif

endmodule
